// File: rtl/parsing_layer_sched.sv
// ----------------------------------------------------------------------------
// parsing_layer_sched
//   Sweeps a layer of tiles through 16 BRAM banks. Each tile gets one LOAD
//   cycle (oStart pulse) followed by RUN cycles that walk a shared word
//   address from 0 to len-1, stalling whenever downstream is not ready.
//   After the last tile, DONE pulses oDone for one cycle.
//
//   Optional feature macro: PARSING_SCHED_STALL_CNT_EN adds oStallCnt, a
//   saturating count of RUN cycles with iReady low for the current layer.
//
// Ports
//   clk          clock, rising edge
//   rst          asynchronous active-high reset
//   iLayerStart  one-cycle layer start request (honoured in IDLE only)
//   iNumTiles    tiles per layer, 0 = no tiles
//   iTileLen     BRAM words per tile, 0 = 512
//   iReady       downstream ready, low stalls the sweep
//   iAbort       cancel the layer
//   oStart       one-cycle start pulse per tile
//   oRun         datapath run enable
//   oCs          chip enables for the 16 banks
//   oAddr        shared BRAM word address
//   oTileIdx     current tile index
//   oBusy        layer in progress
//   oDone        one-cycle layer-complete pulse
//   oStallCnt    (optional) stall cycle count
//
// All outputs are registered. oCs in a RUN cycle reflects the iReady value
// sampled at the edge that opened that cycle.
// ----------------------------------------------------------------------------
module parsing_layer_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        iLayerStart,
    input  logic [7:0]  iNumTiles,
    input  logic [8:0]  iTileLen,
    input  logic        iReady,
    input  logic        iAbort,
    output logic        oStart,
    output logic        oRun,
    output logic [15:0] oCs,
    output logic [8:0]  oAddr,
    output logic [7:0]  oTileIdx,
    output logic        oBusy,
    output logic        oDone
`ifdef PARSING_SCHED_STALL_CNT_EN
    ,
    output logic [15:0] oStallCnt
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

    state_t      r_state;
    logic [7:0]  r_tiles;
    logic [8:0]  r_len;
    logic        r_start;
    logic        r_run;
    logic [15:0] r_cs;
    logic [8:0]  r_addr;
    logic [7:0]  r_tile_idx;
    logic        r_busy;
    logic        r_done;

    logic w_accept;
    logic w_last_addr;
    logic w_last_tile;

    assign w_accept    = (r_state == S_IDLE) && iLayerStart && !iAbort;
    // A stored length of 0 means 512 words: 0 - 1 wraps to 511 in 9 bits.
    assign w_last_addr = (r_addr == (r_len - 9'd1));
    assign w_last_tile = (r_tile_idx == (r_tiles - 8'd1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_tiles    <= '0;
            r_len      <= '0;
            r_start    <= 1'b0;
            r_run      <= 1'b0;
            r_cs       <= '0;
            r_addr     <= '0;
            r_tile_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            // Pulse-type outputs default low every cycle.
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_cs    <= '0;
            if (iAbort && (r_state != S_IDLE)) begin
                // Abort beats tile end and iReady.
                r_state    <= S_IDLE;
                r_run      <= 1'b0;
                r_addr     <= '0;
                r_tile_idx <= '0;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_accept) begin
                            r_tiles    <= iNumTiles;
                            r_len      <= iTileLen;
                            r_addr     <= '0;
                            r_tile_idx <= '0;
                            r_busy     <= 1'b1;
                            if (iNumTiles == 8'd0) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state <= S_LOAD;
                                r_start <= 1'b1;
                            end
                        end
                    end
                    S_LOAD: begin
                        r_state <= S_RUN;
                        r_run   <= 1'b1;
                        r_cs    <= iReady ? 16'hFFFF : 16'h0000;
                    end
                    S_RUN: begin
                        if (iReady && w_last_addr) begin
                            r_run  <= 1'b0;
                            r_addr <= '0;
                            if (w_last_tile) begin
                                r_state <= S_DONE;
                                r_done  <= 1'b1;
                            end else begin
                                r_state    <= S_LOAD;
                                r_start    <= 1'b1;
                                r_tile_idx <= r_tile_idx + 8'd1;
                            end
                        end else begin
                            if (iReady) begin
                                r_addr <= r_addr + 9'd1;
                            end
                            r_cs <= iReady ? 16'hFFFF : 16'h0000;
                        end
                    end
                    S_DONE: begin
                        r_state    <= S_IDLE;
                        r_tile_idx <= '0;
                        r_busy     <= 1'b0;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign oStart   = r_start;
    assign oRun     = r_run;
    assign oCs      = r_cs;
    assign oAddr    = r_addr;
    assign oTileIdx = r_tile_idx;
    assign oBusy    = r_busy;
    assign oDone    = r_done;

`ifdef PARSING_SCHED_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cnt <= '0;
        end else if (w_accept) begin
            r_stall_cnt <= '0;
        end else if ((r_state == S_RUN) && !iReady && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign oStallCnt = r_stall_cnt;
`endif

endmodule

// File: tb/tb_parsing_layer_sched.sv
// ----------------------------------------------------------------------------
// tb_parsing_layer_sched
//   Self-checking bench for parsing_layer_sched. Expected per-cycle output
//   traces are generated from the layer parameters and the iReady pattern by
//   walking tiles and word addresses in plain loops.
//   Cycle k is the clock period that follows edge k-1; the layer start is
//   sampled at edge 0 and iReady driven during cycle k is sampled at edge k.
// ----------------------------------------------------------------------------
module tb_parsing_layer_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        iLayerStart;
    logic [7:0]  iNumTiles;
    logic [8:0]  iTileLen;
    logic        iReady;
    logic        iAbort;
    logic        oStart;
    logic        oRun;
    logic [15:0] oCs;
    logic [8:0]  oAddr;
    logic [7:0]  oTileIdx;
    logic        oBusy;
    logic        oDone;
`ifdef PARSING_SCHED_STALL_CNT_EN
    logic [15:0] oStallCnt;
`endif

    parsing_layer_sched dut (
        .clk        (clk),
        .rst        (rst),
        .iLayerStart(iLayerStart),
        .iNumTiles  (iNumTiles),
        .iTileLen   (iTileLen),
        .iReady     (iReady),
        .iAbort     (iAbort),
        .oStart     (oStart),
        .oRun       (oRun),
        .oCs        (oCs),
        .oAddr      (oAddr),
        .oTileIdx   (oTileIdx),
        .oBusy      (oBusy),
        .oDone      (oDone)
`ifdef PARSING_SCHED_STALL_CNT_EN
        ,
        .oStallCnt  (oStallCnt)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    bit          rdy   [0:4095];
    logic [36:0] exp_v [0:4095];
    int          exp_st[0:4095];
    int          layer_done;
    int          obs_starts;
    int          obs_done_cyc;
    int          obs_max_addr;

    wire [36:0] w_obs = {oStart, oRun, oCs, oAddr, oTileIdx, oBusy, oDone};

    function automatic logic [36:0] pack(bit s, bit r, bit cs, int a, int i, bit b, bit d);
        logic [15:0] csv;
        csv = cs ? 16'hFFFF : 16'h0000;
        return {s, r, csv, 9'(a), 8'(i), b, d};
    endfunction

    task automatic fill_ready(input bit random_mode);
        for (int k = 0; k < 4096; k++)
            rdy[k] = (random_mode && k < 1000) ? ($urandom_range(0, 3) != 0) : 1'b1;
    endtask

    // Builds the expected trace, runs one layer and compares every cycle.
    task automatic run_layer(input int T, input int L, input bit noise);
        int  c, a, eff, st;
        bit  prev;
        eff = (L == 0) ? 512 : L;
        st  = 0;
        c   = 1;
        if (T == 0) begin
            exp_v[1]  = pack(0, 0, 0, 0, 0, 1, 1);
            exp_st[1] = 0;
            c = 2;
        end else begin
            for (int t = 0; t < T; t++) begin
                exp_v[c]  = pack(1, 0, 0, 0, t, 1, 0);
                exp_st[c] = st;
                prev = rdy[c];
                c++;
                a = 0;
                forever begin
                    exp_v[c]  = pack(0, 1, prev, a, t, 1, 0);
                    exp_st[c] = st;
                    if (!rdy[c] && st < 65535) st++;
                    prev = rdy[c];
                    c++;
                    if (prev) begin
                        if (a == eff - 1) break;
                        a++;
                    end
                end
            end
            exp_v[c]  = pack(0, 0, 0, 0, T - 1, 1, 1);
            exp_st[c] = st;
            c++;
        end
        layer_done = c - 1;
        exp_v[c]   = '0;
        exp_st[c]  = st;

        @(posedge clk); #1;
        iLayerStart = 1'b1;
        iNumTiles   = 8'(T);
        iTileLen    = 9'(L);
        iReady      = rdy[0];
        iAbort      = 1'b0;
        obs_starts = 0; obs_done_cyc = 0; obs_max_addr = 0;
        for (int k = 1; k <= layer_done + 1; k++) begin
            @(posedge clk); #1;
            iReady      = rdy[k];
            iLayerStart = (noise && k < layer_done) ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (noise) begin
                iNumTiles = 8'($urandom);
                iTileLen  = 9'($urandom);
            end
            @(negedge clk);
            n_chk++;
            if (w_obs !== exp_v[k]) begin
                n_fail++;
                $display("FAIL layer_trace T=%0d L=%0d cycle %0d: got %h, expected %h", T, L, k, w_obs, exp_v[k]);
            end
`ifdef PARSING_SCHED_STALL_CNT_EN
            n_chk++;
            if (oStallCnt !== 16'(exp_st[k])) begin
                n_fail++;
                $display("FAIL stall_cnt T=%0d L=%0d cycle %0d: got %0d, expected %0d", T, L, k, oStallCnt, exp_st[k]);
            end
`endif
            if (oStart) obs_starts++;
            if (oDone && obs_done_cyc == 0) obs_done_cyc = k;
            if (int'(oAddr) > obs_max_addr) obs_max_addr = int'(oAddr);
        end
        iLayerStart = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; iLayerStart = 1'b0; iNumTiles = '0; iTileLen = '0; iReady = 1'b0; iAbort = 1'b0;
        #1 rst = 1'b1;
        #2;
        n_chk++;
        if (w_obs !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h, expected 0", w_obs);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        n_chk++;
        if (w_obs !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h, expected 0", w_obs);
        end
`ifdef PARSING_SCHED_STALL_CNT_EN
        n_chk++;
        if (oStallCnt !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall: got %0d, expected 0", oStallCnt);
        end
`endif
    endtask

    task automatic test_nominal();
        fill_ready(0);
        run_layer(3, 4, 0);
        n_chk++;
        if (obs_starts != 3 || obs_done_cyc != 16 || obs_max_addr != 3) begin
            n_fail++;
            $display("FAIL nominal_summary: starts %0d done %0d maxaddr %0d, expected 3 16 3", obs_starts, obs_done_cyc, obs_max_addr);
        end
    endtask

    task automatic test_backpressure();
        fill_ready(0);
        rdy[3] = 1'b0;
        rdy[4] = 1'b0;
        run_layer(1, 4, 0);
        n_chk++;
        if (obs_done_cyc != 8) begin
            n_fail++;
            $display("FAIL backpressure_done: got cycle %0d, expected 8", obs_done_cyc);
        end
`ifdef PARSING_SCHED_STALL_CNT_EN
        n_chk++;
        if (oStallCnt !== 16'd2) begin
            n_fail++;
            $display("FAIL backpressure_stall: got %0d, expected 2", oStallCnt);
        end
`endif
    endtask

    task automatic test_zero_and_wrap();
        fill_ready(0);
        run_layer(0, 5, 0);
        n_chk++;
        if (obs_starts != 0 || obs_done_cyc != 1) begin
            n_fail++;
            $display("FAIL zero_tiles: starts %0d done %0d, expected 0 1", obs_starts, obs_done_cyc);
        end
        run_layer(1, 0, 0);
        n_chk++;
        if (obs_max_addr != 511 || obs_done_cyc != 514 || obs_starts != 1) begin
            n_fail++;
            $display("FAIL wrap_512: maxaddr %0d done %0d starts %0d, expected 511 514 1", obs_max_addr, obs_done_cyc, obs_starts);
        end
    endtask

    task automatic test_ignored_start();
        fill_ready(1);
        run_layer(3, 5, 1);
        n_chk++;
        if (obs_starts != 3) begin
            n_fail++;
            $display("FAIL ignored_start: starts %0d, expected 3", obs_starts);
        end
    endtask

    task automatic test_random();
        int T, L;
        for (int n = 0; n < 8; n++) begin
            T = $urandom_range(0, 4);
            L = $urandom_range(1, 8);
            fill_ready(1);
            run_layer(T, L, n[0]);
        end
    endtask

    task automatic test_abort();
        bit done_seen;
        fill_ready(0);
        @(posedge clk); #1;
        iLayerStart = 1'b1; iNumTiles = 8'd3; iTileLen = 9'd4; iReady = 1'b1; iAbort = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            @(posedge clk); #1;
            iLayerStart = 1'b0;
            iAbort = (c == 9);
            @(negedge clk);
        end
        n_chk++;
        if (oAddr !== 9'd2 || oTileIdx !== 8'd1 || oRun !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_position: addr %0d idx %0d run %b, expected 2 1 1", oAddr, oTileIdx, oRun);
        end
        done_seen = 1'b0;
        @(posedge clk); #1;
        iAbort = 1'b0;
        @(negedge clk);
        n_chk++;
        if (w_obs !== 37'd0) begin
            n_fail++;
            $display("FAIL abort_idle: got %h, expected 0", w_obs);
        end
        repeat (6) begin
            @(negedge clk);
            if (oDone || oBusy) done_seen = 1'b1;
        end
        n_chk++;
        if (done_seen) begin
            n_fail++;
            $display("FAIL abort_no_done: got activity after abort, expected none");
        end
        run_layer(1, 2, 0);
        n_chk++;
        if (obs_done_cyc != 4) begin
            n_fail++;
            $display("FAIL abort_restart: done %0d, expected 4", obs_done_cyc);
        end
    endtask

    task automatic test_abort_idle();
        bit active;
        active = 1'b0;
        @(posedge clk); #1;
        iLayerStart = 1'b1; iAbort = 1'b1; iNumTiles = 8'd2; iTileLen = 9'd3;
        @(posedge clk); #1;
        iLayerStart = 1'b0; iAbort = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (w_obs !== 37'd0) active = 1'b1;
        end
        n_chk++;
        if (active) begin
            n_fail++;
            $display("FAIL abort_with_start_idle: layer started, expected nothing");
        end
    endtask

    task automatic test_reset_mid_run();
        bit active;
        fill_ready(0);
        @(posedge clk); #1;
        iLayerStart = 1'b1; iNumTiles = 8'd1; iTileLen = 9'd8; iReady = 1'b1; iAbort = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            @(posedge clk); #1;
            iLayerStart = 1'b0;
            @(negedge clk);
        end
        n_chk++;
        if (oAddr !== 9'd5) begin
            n_fail++;
            $display("FAIL reset_mid_position: addr %0d, expected 5", oAddr);
        end
        #1 rst = 1'b1;
        #1;
        n_chk++;
        if (w_obs !== 37'd0) begin
            n_fail++;
            $display("FAIL reset_mid_async: got %h, expected 0", w_obs);
        end
        #1 rst = 1'b0;
        active = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (w_obs !== 37'd0) active = 1'b1;
        end
        n_chk++;
        if (active) begin
            n_fail++;
            $display("FAIL reset_mid_quiet: activity after reset, expected none");
        end
        run_layer(2, 3, 0);
        n_chk++;
        if (obs_starts != 2 || obs_done_cyc != 9 || obs_max_addr != 2) begin
            n_fail++;
            $display("FAIL reset_restart: starts %0d done %0d maxaddr %0d, expected 2 9 2", obs_starts, obs_done_cyc, obs_max_addr);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_backpressure();
        test_zero_and_wrap();
        test_ignored_start();
        test_abort();
        test_abort_idle();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
